// File: rtl/memory_controller.sv
// memory_controller
//   Command-driven initiator for the 4-byte memory_system. Accepts write,
//   read and dump commands over a valid/ready handshake, sequences the
//   store strobe with address/data setup and hold, and returns read bytes
//   over a valid/ready response channel.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for a command; cmd_ready high
//   W_SETUP  | address/data driven, store low (setup cycle)
//   W_STORE  | store high for STORE_CYCLES cycles
//   W_HOLD   | store low, address/data held (hold cycle)
//   R_SETTLE | address driven for READ_SETTLE cycles before sampling mem_q
//   R_RESP   | response byte presented until rsp_ready
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid/ready/op/addr/data  command channel
//   rsp_valid/ready/data/addr/last response channel
//   mem_data/store/addr, mem_q    memory_system interface
//   busy                          high whenever not IDLE
//
// Parameters (legal range 1-15):
//   STORE_CYCLES  cycles mem_store is held high per write
//   READ_SETTLE   cycles mem_addr is held before mem_q is sampled

module memory_controller #(
    parameter int STORE_CYCLES = 1,
    parameter int READ_SETTLE  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_addr,
    output logic       rsp_last,
    output logic [7:0] mem_data,
    output logic       mem_store,
    output logic [1:0] mem_addr,
    input  logic [7:0] mem_q,
    output logic       busy
);

    localparam logic [3:0] STORE_LOAD  = 4'(STORE_CYCLES);
    localparam logic [3:0] SETTLE_LOAD = 4'(READ_SETTLE);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_DUMP  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STORE,
        W_HOLD,
        R_SETTLE,
        R_RESP
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] idx;
    logic       dump_mode;

    assign cmd_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            idx       <= 2'd0;
            dump_mode <= 1'b0;
            mem_data  <= 8'd0;
            mem_store <= 1'b0;
            mem_addr  <= 2'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
            rsp_addr  <= 2'd0;
            rsp_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_WRITE: begin
                                mem_addr <= cmd_addr;
                                mem_data <= cmd_data;
                                state    <= W_SETUP;
                            end
                            OP_READ: begin
                                mem_addr  <= cmd_addr;
                                dump_mode <= 1'b0;
                                cnt       <= SETTLE_LOAD;
                                state     <= R_SETTLE;
                            end
                            OP_DUMP: begin
                                mem_addr  <= 2'd0;
                                idx       <= 2'd0;
                                dump_mode <= 1'b1;
                                cnt       <= SETTLE_LOAD;
                                state     <= R_SETTLE;
                            end
                            default: ;
                        endcase
                    end
                end
                W_SETUP: begin
                    mem_store <= 1'b1;
                    cnt       <= STORE_LOAD;
                    state     <= W_STORE;
                end
                W_STORE: begin
                    // terminal count at 1: the strobe lasts exactly the load value
                    if (cnt == 4'd1) begin
                        mem_store <= 1'b0;
                        state     <= W_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                W_HOLD: begin
                    state <= IDLE;
                end
                R_SETTLE: begin
                    if (cnt == 4'd1) begin
                        rsp_data  <= mem_q;
                        rsp_addr  <= mem_addr;
                        rsp_last  <= !dump_mode || (idx == 2'd3);
                        rsp_valid <= 1'b1;
                        state     <= R_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            state <= IDLE;
                        end else begin
                            idx      <= idx + 2'd1;
                            mem_addr <= idx + 2'd1;
                            cnt      <= SETTLE_LOAD;
                            state    <= R_SETTLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
